// File: rtl/fifo_ctrl_buffer_if.sv
// fifo_ctrl_buffer_if: strobe, status and data bundle between the FIFO and its users.
interface fifo_ctrl_buffer_if #(
   parameter int WIDTH = 8,
   parameter int AW    = 2
);
   logic             in_write_ctrl;
   logic             in_read_ctrl;
   logic [WIDTH-1:0] in_data;
   logic [WIDTH-1:0] out_data;
   logic             out_is_empty;
   logic             out_is_full;
   logic [AW:0]      out_count;
   logic             out_overflow;
   logic             out_underflow;
   modport master (
      output in_write_ctrl, in_read_ctrl, in_data,
      input  out_data, out_is_empty, out_is_full, out_count, out_overflow, out_underflow
   );
   modport slave (
      input  in_write_ctrl, in_read_ctrl, in_data,
      output out_data, out_is_empty, out_is_full, out_count, out_overflow, out_underflow
   );
endinterface

// File: rtl/fifo_ctrl_buffer.sv
// fifo_ctrl_buffer: single-clock FIFO with registered read data, occupancy count
// and sticky overflow/underflow flags for strobes that ignore the status flags.
module fifo_ctrl_buffer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic              clk,
   input  logic              rst,
   fifo_ctrl_buffer_if.slave bus
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             empty_q, empty_d, full_q, full_d, ovf_q, ovf_d, unf_q, unf_d;
   logic             push_ok, pop_ok;
   // A push into a full FIFO is legal only when the same-cycle pop frees a slot.
   always_comb begin
      push_ok  = bus.in_write_ctrl & (~full_q | bus.in_read_ctrl);
      pop_ok   = bus.in_read_ctrl & ~empty_q;
      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
      data_d   = pop_ok ? mem_q[rd_ptr_q] : data_q;
      count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      empty_d  = count_d == '0;
      full_d   = count_d == (AW+1)'(DEPTH);
      ovf_d    = ovf_q | (bus.in_write_ctrl & full_q & ~bus.in_read_ctrl);
      unf_d    = unf_q | (bus.in_read_ctrl & empty_q);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         data_q   <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         data_q   <= data_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end
   // Storage is deliberately not reset; the count guarantees unwritten words are never read.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= bus.in_data;
   end
   assign bus.out_data      = data_q;
   assign bus.out_is_empty  = empty_q;
   assign bus.out_is_full   = full_q;
   assign bus.out_count     = count_q;
   assign bus.out_overflow  = ovf_q;
   assign bus.out_underflow = unf_q;
endmodule

// File: tb/tb_fifo_ctrl_buffer.sv
// tb_fifo_ctrl_buffer: directed and random traffic against a queue-based reference model;
// expected outputs are queued per cycle and compared by an independent monitor.
module tb_fifo_ctrl_buffer;
   localparam int WIDTH = 8, DEPTH = 4, AW = 2;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   fifo_ctrl_buffer_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
   fifo_ctrl_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   typedef struct {
      logic [WIDTH-1:0] data;
      int               count;
      bit               empty, full, ovf, unf;
   } exp_t;
   exp_t             exp_q[$];
   logic [WIDTH-1:0] mq[$];
   logic [WIDTH-1:0] m_data;
   bit               m_ovf, m_unf;
   int               errors = 0, checks = 0, cyc_n = 0;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
      end
   endtask
   task automatic chk_all(string tag, exp_t e);
      chk({tag, " out_data"}, 32'(bus.out_data), 32'(e.data));
      chk({tag, " out_count"}, 32'(bus.out_count), 32'(e.count));
      chk({tag, " out_is_empty"}, 32'(bus.out_is_empty), 32'(e.empty));
      chk({tag, " out_is_full"}, 32'(bus.out_is_full), 32'(e.full));
      chk({tag, " out_overflow"}, 32'(bus.out_overflow), 32'(e.ovf));
      chk({tag, " out_underflow"}, 32'(bus.out_underflow), 32'(e.unf));
   endtask
   task automatic mdl_reset();
      mq.delete();
      m_data = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask
   function automatic exp_t mdl_exp();
      exp_t e;
      e.data  = m_data;
      e.count = mq.size();
      e.empty = mq.size() == 0;
      e.full  = mq.size() == DEPTH;
      e.ovf   = m_ovf;
      e.unf   = m_unf;
      return e;
   endfunction
   task automatic mdl_step(bit w, bit r, logic [WIDTH-1:0] d);
      bit full  = mq.size() == DEPTH;
      bit empty = mq.size() == 0;
      if (w && full && !r) m_ovf = 1'b1;
      if (r && empty) m_unf = 1'b1;
      if (r && !empty) m_data = mq.pop_front();
      if (w && (!full || r)) mq.push_back(d);
   endtask
   // One clock of stimulus: drive at negedge, queue the model's post-edge view at posedge.
   task automatic cyc(bit w, bit r, logic [WIDTH-1:0] d);
      exp_t e;
      bus.in_write_ctrl = w;
      bus.in_read_ctrl  = r;
      bus.in_data       = d;
      mdl_step(w, r, d);
      e = mdl_exp();
      @(posedge clk);
      exp_q.push_back(e);
      @(negedge clk);
      bus.in_write_ctrl = 1'b0;
      bus.in_read_ctrl  = 1'b0;
   endtask
   task automatic push(logic [WIDTH-1:0] d); cyc(1'b1, 1'b0, d); endtask
   task automatic pop(); cyc(1'b0, 1'b1, '0); endtask
   task automatic do_reset();
      #2 rst = 1'b0;
      #1;
      mdl_reset();
      chk_all("async reset", mdl_exp());
      @(negedge clk);
      rst = 1'b1;
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk_all("cycle", e);
      end
      cyc_n++;
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
   initial begin
      bus.in_write_ctrl = 1'b0;
      bus.in_read_ctrl  = 1'b0;
      bus.in_data       = '0;
      mdl_reset();
      @(negedge clk);
      chk_all("reset held", mdl_exp());
      rst = 1'b1;
      repeat (3) cyc(1'b0, 1'b0, '0);
      push(8'h5A);
      push(8'hC3);
      do_reset();
      for (int i = 1; i <= 4; i++) push(8'(i * 8'h11));
      repeat (4) pop();
      for (int i = 0; i < 3; i++) push(8'(i + 1));
      repeat (3) pop();
      for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
      repeat (4) pop();
      for (int i = 1; i <= 4; i++) push(8'(i * 8'h11));
      cyc(1'b1, 1'b1, 8'h55);
      repeat (4) pop();
      for (int i = 1; i <= 4; i++) push(8'(i * 8'h10));
      push(8'h66);
      repeat (4) pop();
      pop();
      push(8'h01);
      cyc(1'b1, 1'b1, 8'h02);
      repeat (2) pop();
      do_reset();
      cyc(1'b1, 1'b1, 8'h77);
      pop();
      // Random traffic in phases biased toward filling, draining and balanced use.
      for (int p = 0; p < 8; p++) begin
         int pw = (p % 3 == 0) ? 80 : (p % 3 == 1) ? 20 : 50;
         int pr = (p % 3 == 0) ? 20 : (p % 3 == 1) ? 80 : 50;
         for (int i = 0; i < 50; i++)
            cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom));
         if (p == 4) do_reset();
      end
      repeat (2) @(negedge clk);
      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
